// File: rtl/key_parser.sv
// Keypad token parser: builds hex operands, issues {A, B, opcode} to the ALU and latches results.
// Optional KEY_PARSER_REPEAT_EQ_EN: '=' after a good result re-issues the last operation.
module key_parser #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_op_a,
    output logic [WIDTH-1:0] o_op_b,
    output logic [1:0]       o_opcode,
    output logic             o_cmd_valid,
    input  logic             i_cmd_ready,
    input  logic [WIDTH-1:0] i_res,
    input  logic             i_res_err,
    input  logic             i_res_valid,
    output logic [WIDTH-1:0] o_display,
    output logic             o_err
);
    localparam int D  = WIDTH / 4;
    localparam int CW = $clog2(D + 1);

    typedef enum logic [2:0] {ENTER_A, OP_PEND, ENTER_B, ISSUE, WAIT_RES, SHOW} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [1:0]       opcode_q, opcode_d, chain_op_q, chain_op_d;
    logic             chain_vld_q, chain_vld_d;
    logic             err_q, err_d;

    logic       accept, is_dig, is_op, is_eq, is_ac, dig_nz;
    logic [3:0] dig;
    logic [1:0] tok_op;

    assign dig    = i_data[3:0];
    assign is_dig = !i_data[4];
    assign dig_nz = (dig != 4'd0);
    assign is_ac  = (i_data == 5'h10);
    assign is_op  = (i_data >= 5'h11) && (i_data <= 5'h14);
    assign is_eq  = (i_data == 5'h15);
    assign tok_op = i_data[1:0] - 2'd1;

    assign o_ready = !rst && (state_q == ENTER_A || state_q == OP_PEND ||
                              state_q == ENTER_B || state_q == SHOW);
    assign accept  = i_valid && o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ENTER_A;
            a_q         <= '0;
            b_q         <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            opcode_q    <= '0;
            chain_op_q  <= '0;
            chain_vld_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            opcode_q    <= opcode_d;
            chain_op_q  <= chain_op_d;
            chain_vld_q <= chain_vld_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        opcode_d    = opcode_q;
        chain_op_d  = chain_op_q;
        chain_vld_d = chain_vld_q;
        err_d       = err_q;
        if (accept && is_ac) begin
            a_d         = '0;
            b_d         = '0;
            cnt_a_d     = '0;
            cnt_b_d     = '0;
            chain_vld_d = 1'b0;
            err_d       = 1'b0;
            state_d     = ENTER_A;
        end else begin
            case (state_q)
                ENTER_A: if (accept) begin
                    // Leading zeros do not count toward the digit limit.
                    if (is_dig && cnt_a_q != CW'(D)) begin
                        a_d = (a_q << 4) | WIDTH'(dig);
                        if (dig_nz || cnt_a_q != '0) cnt_a_d = cnt_a_q + CW'(1);
                    end else if (is_op) begin
                        opcode_d = tok_op;
                        state_d  = OP_PEND;
                    end
                end
                OP_PEND: if (accept) begin
                    if (is_op) begin
                        opcode_d = tok_op;
                    end else if (is_dig) begin
                        b_d     = WIDTH'(dig);
                        cnt_b_d = dig_nz ? CW'(1) : '0;
                        state_d = ENTER_B;
                    end
                end
                ENTER_B: if (accept) begin
                    if (is_dig && cnt_b_q != CW'(D)) begin
                        b_d = (b_q << 4) | WIDTH'(dig);
                        if (dig_nz || cnt_b_q != '0) cnt_b_d = cnt_b_q + CW'(1);
                    end else if (is_eq) begin
                        chain_vld_d = 1'b0;
                        state_d     = ISSUE;
                    end else if (is_op) begin
                        chain_vld_d = 1'b1;
                        chain_op_d  = tok_op;
                        state_d     = ISSUE;
                    end
                end
                ISSUE: if (i_cmd_ready) state_d = WAIT_RES;
                WAIT_RES: if (i_res_valid) begin
                    a_d         = i_res;
                    err_d       = i_res_err;
                    cnt_a_d     = CW'(D);
                    chain_vld_d = 1'b0;
                    if (chain_vld_q && !i_res_err) begin
                        opcode_d = chain_op_q;
                        state_d  = OP_PEND;
                    end else begin
                        state_d  = SHOW;
                    end
                end
                SHOW: if (accept) begin
                    if (is_dig) begin
                        a_d     = WIDTH'(dig);
                        cnt_a_d = dig_nz ? CW'(1) : '0;
                        err_d   = 1'b0;
                        state_d = ENTER_A;
                    end else if (is_op && !err_q) begin
                        opcode_d = tok_op;
                        state_d  = OP_PEND;
                    end
`ifdef KEY_PARSER_REPEAT_EQ_EN
                    else if (is_eq && !err_q) begin
                        chain_vld_d = 1'b0;
                        state_d     = ISSUE;
                    end
`endif
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    assign o_op_a      = a_q;
    assign o_op_b      = b_q;
    assign o_opcode    = opcode_q;
    assign o_cmd_valid = (state_q == ISSUE);
    assign o_err       = err_q;
    assign o_display   = (state_q == ENTER_B || state_q == ISSUE || state_q == WAIT_RES) ? b_q : a_q;
endmodule

// File: tb/tb_key_parser.sv
// Directed bench for key_parser: token table for operand entry plus hand sequences for ALU exchanges.
module tb_key_parser;
    localparam int W = 16;
    localparam logic [4:0] T_AC = 5'h10, T_ADD = 5'h11, T_SUB = 5'h12, T_MUL = 5'h13,
                           T_DIV = 5'h14, T_EQ = 5'h15, T_RSV = 5'h16;

    logic         clk = 1'b0, rst = 1'b1;
    logic [4:0]   i_data = '0;
    logic         i_valid = 1'b0, i_cmd_ready = 1'b0, i_res_err = 1'b0, i_res_valid = 1'b0;
    logic [W-1:0] i_res = '0;
    logic         o_ready, o_cmd_valid, o_err;
    logic [W-1:0] o_op_a, o_op_b, o_display;
    logic [1:0]   o_opcode;

    int n_chk = 0, n_err = 0;

    key_parser #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_op_a(o_op_a), .o_op_b(o_op_b), .o_opcode(o_opcode), .o_cmd_valid(o_cmd_valid),
        .i_cmd_ready(i_cmd_ready), .i_res(i_res), .i_res_err(i_res_err),
        .i_res_valid(i_res_valid), .o_display(o_display), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   tok;
        logic [W-1:0] disp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic send(input logic [4:0] tok);
        int n = 0;
        while (!o_ready && n < 20) begin @(negedge clk); n++; end
        chk("send_ready", 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_data  = tok;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic take_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                            input bit res_same_cycle);
        int n = 0;
        while (!o_cmd_valid && n < 20) begin @(negedge clk); n++; end
        chk("cmd_valid", 32'(o_cmd_valid), 32'd1);
        chk("cmd_a", 32'(o_op_a), 32'(a));
        chk("cmd_b", 32'(o_op_b), 32'(b));
        chk("cmd_op", 32'(o_opcode), 32'(op));
        i_cmd_ready = 1'b1;
        if (res_same_cycle) begin
            i_res_valid = 1'b1;
            i_res       = 16'h0077;
        end
        @(negedge clk);
        i_cmd_ready = 1'b0;
        i_res_valid = 1'b0;
        chk("cmd_valid_fall", 32'(o_cmd_valid), 32'd0);
        chk("ready_wait_res", 32'(o_ready), 32'd0);
    endtask

    task automatic ret(input logic [W-1:0] res, input logic err);
        i_res_valid = 1'b1;
        i_res       = res;
        i_res_err   = err;
        @(negedge clk);
        i_res_valid = 1'b0;
        i_res_err   = 1'b0;
    endtask

    initial begin
        vec_t tbl[15];
        tbl[0]  = '{T_AC,  16'h0000};
        tbl[1]  = '{5'h00, 16'h0000};
        tbl[2]  = '{5'h00, 16'h0000};
        tbl[3]  = '{5'h01, 16'h0001};
        tbl[4]  = '{5'h02, 16'h0012};
        tbl[5]  = '{5'h03, 16'h0123};
        tbl[6]  = '{5'h04, 16'h1234};
        tbl[7]  = '{5'h05, 16'h1234};
        tbl[8]  = '{T_RSV, 16'h1234};
        tbl[9]  = '{T_EQ,  16'h1234};
        tbl[10] = '{5'h09, 16'h1234};
        tbl[11] = '{T_SUB, 16'h1234};
        tbl[12] = '{5'h00, 16'h0000};
        tbl[13] = '{5'h07, 16'h0007};
        tbl[14] = '{T_AC,  16'h0000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
        chk("rst_display", 32'(o_display), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_op_a", 32'(o_op_a), 32'd0);
        chk("rst_op_b", 32'(o_op_b), 32'd0);
        chk("rst_opcode", 32'(o_opcode), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(o_ready), 32'd1);

        // 12 + 3 = 15
        send(5'h01); send(5'h02); send(T_ADD); send(5'h03); send(T_EQ);
        chk("issue_display_b", 32'(o_display), 32'h3);
        take_cmd(16'h0012, 16'h0003, 2'b00, 1'b0);
        ret(16'h0015, 1'b0);
        chk("show_display", 32'(o_display), 32'h15);
        chk("show_ready", 32'(o_ready), 32'd1);

        // Operand entry table
        for (int i = 0; i < 15; i++) begin
            send(tbl[i].tok);
            chk($sformatf("tbl_disp[%0d]", i), 32'(o_display), 32'(tbl[i].disp));
        end

        // Chained op; result returned in the handshake cycle must be ignored
        send(5'h09); send(T_SUB); send(5'h04); send(T_MUL);
        take_cmd(16'h0009, 16'h0004, 2'b01, 1'b0);
        ret(16'h0005, 1'b0);
        chk("chain_opcode", 32'(o_opcode), 32'd2);
        chk("chain_display", 32'(o_display), 32'h5);
        chk("chain_ready", 32'(o_ready), 32'd1);
        send(5'h02); send(T_EQ);
        take_cmd(16'h0005, 16'h0002, 2'b10, 1'b1);
        chk("early_res_display", 32'(o_display), 32'h2);
        ret(16'h000a, 1'b0);
        chk("mul_display", 32'(o_display), 32'ha);
        chk("mul_err", 32'(o_err), 32'd0);

        // Divide by zero error, op ignored, digit clears
        send(T_AC); send(5'h08); send(T_DIV); send(5'h00); send(T_EQ);
        take_cmd(16'h0008, 16'h0000, 2'b11, 1'b0);
        ret(16'h0000, 1'b1);
        chk("div0_err", 32'(o_err), 32'd1);
        chk("div0_ready", 32'(o_ready), 32'd1);
        send(T_ADD);
        chk("err_op_ignored", 32'(o_err), 32'd1);
        send(5'h07);
        chk("err_cleared", 32'(o_err), 32'd0);
        chk("err_new_a", 32'(o_display), 32'h7);
        send(5'h08);
        chk("err_new_a2", 32'(o_display), 32'h78);

        // Backpressure in ISSUE, then reset mid-command
        send(T_AC); send(5'h01); send(T_ADD); send(5'h02); send(T_EQ);
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_data  = 5'h05;
            chk("stall_valid", 32'(o_cmd_valid), 32'd1);
            chk("stall_a", 32'(o_op_a), 32'h1);
            chk("stall_b", 32'(o_op_b), 32'h2);
            chk("stall_op", 32'(o_opcode), 32'd0);
            chk("stall_ready", 32'(o_ready), 32'd0);
            @(negedge clk);
        end
        i_valid = 1'b0;
        chk("stall_no_consume", 32'(o_display), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_valid", 32'(o_cmd_valid), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd0);
        chk("midrst_display", 32'(o_display), 32'd0);
        chk("midrst_op_a", 32'(o_op_a), 32'd0);
        chk("midrst_op_b", 32'(o_op_b), 32'd0);
        chk("midrst_opcode", 32'(o_opcode), 32'd0);
        rst = 1'b0;
        ret(16'h0099, 1'b0);
        chk("late_res_ignored", 32'(o_display), 32'd0);
        chk("late_res_ready", 32'(o_ready), 32'd1);

        // Repeated '='
        send(5'h02); send(T_MUL); send(5'h03); send(T_EQ);
        take_cmd(16'h0002, 16'h0003, 2'b10, 1'b0);
        ret(16'h0006, 1'b0);
        send(T_EQ);
`ifdef KEY_PARSER_REPEAT_EQ_EN
        take_cmd(16'h0006, 16'h0003, 2'b10, 1'b0);
        ret(16'h0012, 1'b0);
        chk("repeat_display", 32'(o_display), 32'h12);
`else
        repeat (3) begin
            chk("no_repeat_cmd", 32'(o_cmd_valid), 32'd0);
            @(negedge clk);
        end
        chk("no_repeat_ready", 32'(o_ready), 32'd1);
        chk("no_repeat_display", 32'(o_display), 32'h6);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/key_parser.md
# key_parser

Consumes the 5-bit key-token stream produced by the keypad scanner and turns it into ALU commands. Assembles hex operands digit by digit, tracks the pending operator, issues `{A, B, opcode}` to the arithmetic unit over a valid/ready handshake, and captures the returned result as the next left operand. Sits between the keypad front end and the ALU, and also drives the display value.

## Interface
- `WIDTH`, 16: operand width in bits; multiple of 4. Max digits `D = WIDTH/4`.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `i_data`  in  5  key token: `0dddd` = hex digit `dddd`; `10000` AC, `10001` +, `10010` -, `10011` *, `10100` /, `10101` =; `10110`, `10111`, `11xxx` reserved.
- `i_valid`  in  1  token valid.
- `o_ready`  out  1  parser accepts a token this cycle.
- `o_op_a`  out  WIDTH  left operand.
- `o_op_b`  out  WIDTH  right operand.
- `o_opcode`  out  2  00 add, 01 sub, 10 mul, 11 div (token low bits minus 1).
- `o_cmd_valid`  out  1  command valid.
- `i_cmd_ready`  in  1  ALU accepts command.
- `i_res`  in  WIDTH  ALU result.
- `i_res_err`  in  1  result error (e.g. divide by zero); qualified by `i_res_valid`.
- `i_res_valid`  in  1  one-cycle result strobe; no backpressure.
- `o_display`  out  WIDTH  value to show.
- `o_err`  out  1  error latched.

## Operation
- States: ENTER_A, OP_PEND, ENTER_B, ISSUE, WAIT_RES, SHOW.
- `o_ready` = 1 in ENTER_A, OP_PEND, ENTER_B, SHOW. It is 0 in ISSUE and WAIT_RES, and 0 while `rst` is high.
- Token accepted when `i_valid && o_ready`. Reserved tokens are consumed with no effect.
- Digit entry into register R (A or B): `R <= {R[WIDTH-5:0], d}`. The digit count increments only if `d != 0` or count > 0, so leading zeros are free. When count == D, further digits are consumed and ignored.
- ENTER_A:
  - digit → shift into A.
  - op (+ - * /) → latch opcode, go to OP_PEND.
  - `=` → ignored.
- OP_PEND:
  - op → replace opcode.
  - digit → B = d, count_B per rule, go to ENTER_B.
  - `=` → ignored.
- ENTER_B:
  - digit → shift into B.
  - `=` → ISSUE, no chained op.
  - op → ISSUE, with that op stored as the chained op.
- ISSUE: `o_cmd_valid` = 1, payload stable; on `i_cmd_ready` go to WAIT_RES.
- WAIT_RES: on `i_res_valid`, set A = `i_res`, `o_err` = `i_res_err`, count_A = D (full, no further digits append).
  - Chained op present and no error → OP_PEND with opcode = chained op; chained op cleared.
  - Otherwise → SHOW.
- SHOW:
  - digit → A = d, count restarts, `o_err` cleared, go to ENTER_A.
  - op → OP_PEND, unless `o_err`, in which case ignored.
  - `=` → see Configuration.
- AC, accepted in any accepting state: A = B = 0, counts 0, chained op cleared, `o_err` = 0, go to ENTER_A. AC is not seen in ISSUE or WAIT_RES because `o_ready` is 0 there.
- `o_display` = A in ENTER_A, OP_PEND, SHOW; B in ENTER_B, ISSUE, WAIT_RES.
- `i_res_valid` is ignored outside WAIT_RES.

## Timing
- Reset values: state ENTER_A, all registers 0, `o_cmd_valid` 0, `o_err` 0, `o_display` 0, `o_op_*` 0, `o_opcode` 00. `o_ready` rises the first cycle after `rst` falls.
- Token effects are visible the cycle after acceptance.
- `o_cmd_valid` rises the cycle after the completing token. It holds with constant `o_op_a`, `o_op_b`, `o_opcode` until the handshake cycle and falls the next cycle.
- Result is captured on the `i_res_valid` edge; the new state and `o_ready` = 1 take effect the next cycle.
- `i_res_valid` in the same cycle as the command handshake is ignored, because the state is still ISSUE.
- Reset mid-command drops `o_cmd_valid` the next cycle. A late `i_res_valid` after reset is ignored.

## Configuration
- `KEY_PARSER_REPEAT_EQ_EN` defined:
  - `=` in SHOW with no error reissues the last opcode, with A = current result and B = last B (B is retained after issue).
  - Goes to ISSUE, with no chained op.
- Undefined: `=` in SHOW is consumed and ignored.

## Test plan
- Reset, then tokens `1`,`2`,`+`,`3`,`=`; ALU returns `0x15` → command A=0x0012, B=0x0003, opcode 00. Then SHOW, `o_display`=0x0015, `o_ready`=1.
- 6 digit tokens `0,0,1,2,3,4`, then `5` (WIDTH=16) → A=0x1234. `5` is consumed and A is unchanged.
- `9`,`-`,`4`,`*` → cmd {9,4,01}; return 5 → OP_PEND, opcode 10. Then `2`,`=` → cmd {5,2,10}.
- `8`,`/`,`0`,`=`; return `i_res_err`=1 → SHOW, `o_err`=1. Then `+` is ignored; `7` clears `o_err`, giving A=7.
- Hold `i_cmd_ready`=0 for 5 cycles in ISSUE → `o_cmd_valid` and payload stable, `o_ready`=0, tokens not consumed. Also assert `rst` mid-ISSUE → all outputs at reset values the next cycle.
- With macro: `2`,`*`,`3`,`=`, return 6, then `=` → cmd {6,3,10}. Without macro: second `=` → no command.
